// File: rtl/pico_mem_model.sv
// PicoRV32 native-bus memory slave with RAM, console and test-result registers; responds W+1 cycles after acceptance.
// No backpressure: one request at a time, mem_valid sampled only in IDLE, mem_ready is a one-cycle strobe.
module pico_mem_model #(
  parameter int          MEM_WORDS = 16384,
  parameter int          LATENCY   = 0,
  parameter int          RAND_WAIT = 0,
  parameter int          MAX_WAIT  = 7,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [31:0] OUT_ADDR  = 32'h1000_0000,
  parameter logic [31:0] TEST_ADDR = 32'h2000_0000,
  parameter logic [31:0] PASS_CODE = 32'd123456789,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        trap,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  output logic        test_done,
  output logic        test_pass,
  output logic        bus_err,
  output logic [31:0] fetch_count
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;
  logic [3:0]  wait_cnt;
  logic [15:0] lfsr;

  logic [31:0] mem [MEM_WORDS];

  logic [3:0]    wait_load;
  logic          lfsr_fb;
  logic          ram_hit;
  logic          out_hit;
  logic          test_hit;
  logic          is_write;
  logic          fire;
  logic          test_wr;
  logic [AW-1:0] ram_idx;
  logic [31:0]   old_word;
  logic [31:0]   new_word;

  assign wait_load = (RAND_WAIT != 0) ? (lfsr[3:0] & 4'(MAX_WAIT)) : 4'(LATENCY);
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign ram_hit   = addr_q[31:2] < 30'(MEM_WORDS);
  assign out_hit   = (addr_q == OUT_ADDR);
  assign test_hit  = (addr_q == TEST_ADDR);
  assign ram_idx   = addr_q[AW+1:2];
  assign old_word  = mem[ram_idx];
  assign is_write  = |wstrb_q;
  // WAIT is always visited once so that ready lands W+1 edges after acceptance, W=0 included.
  assign fire      = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign test_wr   = fire && !ram_hit && !out_hit && test_hit && is_write && !test_done;

  always_comb begin
    new_word = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) new_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Commit on the RESP-entry edge only, so a request aborted by reset never touches RAM.
  always_ff @(posedge clk) begin
    if (fire && ram_hit && is_write) mem[ram_idx] <= new_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      instr_q     <= 1'b0;
      wait_cnt    <= '0;
      lfsr        <= LFSR_SEED;
      mem_ready   <= 1'b0;
      mem_rdata   <= '0;
      cons_valid  <= 1'b0;
      cons_data   <= '0;
      test_done   <= 1'b0;
      test_pass   <= 1'b0;
      bus_err     <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            wstrb_q  <= mem_wstrb;
            instr_q  <= mem_instr;
            wait_cnt <= wait_load;
            lfsr     <= {lfsr[14:0], lfsr_fb};
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= S_RESP;
            mem_ready <= 1'b1;
            if (instr_q) fetch_count <= fetch_count + 32'd1;
            if (ram_hit) begin
              mem_rdata <= old_word;
            end else if (out_hit) begin
              mem_rdata <= '0;
              if (is_write) begin
                cons_valid <= 1'b1;
                cons_data  <= wdata_q[7:0];
              end
            end else if (test_hit) begin
              mem_rdata <= '0;
            end else begin
              mem_rdata <= 32'hDEAD_BEEF;
              bus_err   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          mem_ready  <= 1'b0;
          mem_rdata  <= '0;
          cons_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // A test-register write in the same cycle as a trap takes priority.
      if (test_wr) begin
        test_done <= 1'b1;
        test_pass <= (wdata_q == PASS_CODE);
      end else if (trap && !test_done) begin
        test_done <= 1'b1;
        test_pass <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pico_mem_model.sv
// Bench for pico_mem_model: fixed-latency instance (index 0) driven from a vector table and
// hand sequences, random-wait instance (index 1) driven randomly against a word-array model.
module tb_pico_mem_model;

  localparam logic [31:0] OUT_A  = 32'h1000_0000;
  localparam logic [31:0] TEST_A = 32'h2000_0000;
  localparam logic [31:0] PASS_C = 32'd123456789;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn  [2];
  logic        valid [2];
  logic        instr [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        trap  [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        cv    [2];
  logic [7:0]  cd    [2];
  logic        done  [2];
  logic        pass  [2];
  logic        berr  [2];
  logic [31:0] fcnt  [2];

  int errors = 0;
  int checks = 0;

  pico_mem_model #(.LATENCY(3)) dut_a (
    .clk(clk), .resetn(rstn[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .trap(trap[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .cons_valid(cv[0]), .cons_data(cd[0]),
    .test_done(done[0]), .test_pass(pass[0]), .bus_err(berr[0]), .fetch_count(fcnt[0])
  );

  pico_mem_model #(.RAND_WAIT(1), .MAX_WAIT(7)) dut_b (
    .clk(clk), .resetn(rstn[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .trap(trap[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .cons_valid(cv[1]), .cons_data(cd[1]),
    .test_done(done[1]), .test_pass(pass[1]), .bus_err(berr[1]), .fetch_count(fcnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction; lat counts edges from acceptance to the edge that raised mem_ready.
  task automatic xfer(input int s, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, input logic ins,
                      output logic [31:0] rd, output int lat, output int ncons, output logic [7:0] cdat);
    @(negedge clk);
    valid[s] = 1'b1; addr[s] = a; wdata[s] = d; wstrb[s] = st; instr[s] = ins;
    lat = -1; ncons = 0; rd = '0; cdat = '0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (cv[s]) begin ncons++; cdat = cd[s]; end
      if (ready[s]) begin lat = n - 1; rd = rdata[s]; break; end
    end
    valid[s] = 1'b0; wstrb[s] = '0; instr[s] = 1'b0;
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout: no mem_ready within 64 cycles at addr %h", a);
    end else begin
      @(negedge clk);
      if (cv[s]) ncons++;
      chk("ready_pulse", 32'(ready[s]), 32'd0);
      chk("rdata_idle", rdata[s], 32'd0);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  st;
    logic        ins;
    logic        chk_rd;
    logic [31:0] exp_rd;
    int          exp_cons;
    logic [7:0]  exp_cd;
    logic        exp_err;
    logic        exp_done;
    logic        exp_pass;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                              input logic ins, input logic c, input logic [31:0] er, input int ec,
                              input logic [7:0] ecd, input logic ee, input logic edn, input logic ep);
    vec_t v;
    v.a = a; v.d = d; v.st = st; v.ins = ins; v.chk_rd = c; v.exp_rd = er;
    v.exp_cons = ec; v.exp_cd = ecd; v.exp_err = ee; v.exp_done = edn; v.exp_pass = ep;
    return v;
  endfunction

  vec_t        tbl [$];
  logic [31:0] rd;
  int          lat, ncons, nfetch, timed_out;
  logic [7:0]  cdat;
  logic [15:0] ml;
  logic [31:0] mdl [16];
  int          lats [$];

  initial begin
    for (int s = 0; s < 2; s++) begin
      rstn[s] = 1'b0; valid[s] = 1'b0; instr[s] = 1'b0; addr[s] = '0;
      wdata[s] = '0; wstrb[s] = '0; trap[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready[0]), 0);
    chk("rst_rdata", rdata[0], 0);
    chk("rst_cons_valid", 32'(cv[0]), 0);
    chk("rst_cons_data", 32'(cd[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_pass", 32'(pass[0]), 0);
    chk("rst_bus_err", 32'(berr[0]), 0);
    chk("rst_fetch", fcnt[0], 0);
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // addr, data, wstrb, instr, chk_rd, exp_rd, cons pulses, cons byte, bus_err, done, pass
    tbl.push_back(mk(32'h0,         32'h13,       4'hF, 0, 0, 0,            0, 0,     0, 0, 0));
    tbl.push_back(mk(32'h0,         0,            4'h0, 1, 1, 32'h13,       0, 0,     0, 0, 0));
    tbl.push_back(mk(32'h100,       32'h11223344, 4'hF, 0, 0, 0,            0, 0,     0, 0, 0));
    tbl.push_back(mk(32'h100,       32'hAABBCCDD, 4'h5, 0, 1, 32'h11223344, 0, 0,     0, 0, 0));
    tbl.push_back(mk(32'h100,       0,            4'h0, 1, 1, 32'h11BB33DD, 0, 0,     0, 0, 0));
    tbl.push_back(mk(32'h100,       32'h99000000, 4'h8, 0, 1, 32'h11BB33DD, 0, 0,     0, 0, 0));
    tbl.push_back(mk(32'h100,       0,            4'h0, 0, 1, 32'h99BB33DD, 0, 0,     0, 0, 0));
    tbl.push_back(mk(OUT_A,         32'h41,       4'hF, 0, 1, 0,            1, 8'h41, 0, 0, 0));
    tbl.push_back(mk(OUT_A,         0,            4'h0, 0, 1, 0,            0, 0,     0, 0, 0));
    tbl.push_back(mk(TEST_A,        0,            4'h0, 0, 1, 0,            0, 0,     0, 0, 0));
    tbl.push_back(mk(32'h0800_0000, 0,            4'h0, 0, 1, 32'hDEADBEEF, 0, 0,     1, 0, 0));
    tbl.push_back(mk(32'h0,         0,            4'h0, 1, 1, 32'h13,       0, 0,     1, 0, 0));
    tbl.push_back(mk(32'h0800_0000, 32'h12345678, 4'hF, 0, 1, 32'hDEADBEEF, 0, 0,     1, 0, 0));
    tbl.push_back(mk(32'hFFFC,      32'hCAFEF00D, 4'hF, 0, 0, 0,            0, 0,     1, 0, 0));
    tbl.push_back(mk(32'hFFFC,      0,            4'h0, 0, 1, 32'hCAFEF00D, 0, 0,     1, 0, 0));
    tbl.push_back(mk(32'h10000,     0,            4'h0, 0, 1, 32'hDEADBEEF, 0, 0,     1, 0, 0));
    tbl.push_back(mk(32'h0,         0,            4'h0, 1, 1, 32'h13,       0, 0,     1, 0, 0));
    tbl.push_back(mk(TEST_A,        PASS_C,       4'hF, 0, 1, 0,            0, 0,     1, 1, 1));
    tbl.push_back(mk(TEST_A,        0,            4'hF, 0, 1, 0,            0, 0,     1, 1, 1));
    tbl.push_back(mk(TEST_A,        0,            4'h0, 0, 1, 0,            0, 0,     1, 1, 1));

    nfetch = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      xfer(0, tbl[i].a, tbl[i].d, tbl[i].st, tbl[i].ins, rd, lat, ncons, cdat);
      if (tbl[i].ins) nfetch++;
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      if (tbl[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("v%0d_cons_pulses", i), 32'(ncons), 32'(tbl[i].exp_cons));
      if (tbl[i].exp_cons > 0) chk($sformatf("v%0d_cons_data", i), 32'(cdat), 32'(tbl[i].exp_cd));
      chk($sformatf("v%0d_bus_err", i), 32'(berr[0]), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_done", i), 32'(done[0]), 32'(tbl[i].exp_done));
      chk($sformatf("v%0d_pass", i), 32'(pass[0]), 32'(tbl[i].exp_pass));
    end
    chk("fetch_count", fcnt[0], 32'(nfetch));

    // Reset while waiting: outputs clear at once, pending write never reaches RAM.
    @(negedge clk);
    valid[0] = 1'b1; addr[0] = 32'h100; wdata[0] = 32'hFFFFFFFF; wstrb[0] = 4'hF;
    repeat (2) @(negedge clk);
    rstn[0] = 1'b0;
    #1;
    chk("arst_ready", 32'(ready[0]), 0);
    chk("arst_bus_err", 32'(berr[0]), 0);
    chk("arst_done", 32'(done[0]), 0);
    chk("arst_fetch", fcnt[0], 0);
    valid[0] = 1'b0; wstrb[0] = '0;
    repeat (3) @(negedge clk);
    chk("arst_ready_hold", 32'(ready[0]), 0);
    rstn[0] = 1'b1;
    xfer(0, 32'h100, 0, 4'h0, 0, rd, lat, ncons, cdat);
    chk("post_rst_rdata", rd, 32'h99BB33DD);
    chk("post_rst_latency", 32'(lat), 32'd4);

    // Trap alone ends the test as a fail; a later pass-code write is ignored.
    @(negedge clk); trap[0] = 1'b1;
    @(negedge clk); trap[0] = 1'b0;
    chk("trap_done", 32'(done[0]), 1);
    chk("trap_pass", 32'(pass[0]), 0);
    xfer(0, TEST_A, PASS_C, 4'hF, 0, rd, lat, ncons, cdat);
    chk("trap_sticky_pass", 32'(pass[0]), 0);

    // Trap exactly on the edge that completes a pass-code write: the write wins.
    rstn[0] = 1'b0; @(negedge clk); rstn[0] = 1'b1; @(negedge clk);
    valid[0] = 1'b1; addr[0] = TEST_A; wdata[0] = PASS_C; wstrb[0] = 4'hF;
    timed_out = 1;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      trap[0] = (n == 4);
      if (ready[0]) begin timed_out = 0; lat = n - 1; break; end
    end
    trap[0] = 1'b0; valid[0] = 1'b0; wstrb[0] = '0;
    if (timed_out != 0) begin
      checks++; errors++;
      $display("FAIL trap_race_timeout: no mem_ready within 64 cycles");
    end
    chk("trap_race_latency", 32'(lat), 32'd4);
    chk("trap_race_done", 32'(done[0]), 1);
    chk("trap_race_pass", 32'(pass[0]), 1);
    @(negedge clk);

    // Random-wait instance against a word-array model and a spec-level LFSR.
    ml = 16'hACE1;
    for (int w = 0; w < 16; w++) begin
      mdl[w] = $urandom;
      xfer(1, 32'(w * 4), mdl[w], 4'hF, 0, rd, lat, ncons, cdat);
      chk($sformatf("rinit%0d_latency", w), 32'(lat), 32'(int'(ml[3:0] & 4'd7) + 1));
      ml = lfsr_step(ml);
      lats.push_back(lat);
    end
    for (int i = 0; i < 100; i++) begin
      int          idx;
      logic [31:0] d;
      logic [3:0]  st;
      logic [31:0] exp_old;
      idx = $urandom_range(15);
      d = $urandom;
      st = ($urandom_range(1) == 1) ? 4'($urandom_range(15)) : 4'h0;
      exp_old = mdl[idx];
      xfer(1, 32'(idx * 4), d, st, 0, rd, lat, ncons, cdat);
      chk($sformatf("rand%0d_rdata", i), rd, exp_old);
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(int'(ml[3:0] & 4'd7) + 1));
      chk($sformatf("rand%0d_wait_range", i), 32'(lat >= 1 && lat <= 8), 32'd1);
      ml = lfsr_step(ml);
      lats.push_back(lat);
      for (int b = 0; b < 4; b++) if (st[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    end

    // Same seed after reset: the wait sequence repeats from the start.
    rstn[1] = 1'b0; @(negedge clk); rstn[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      xfer(1, 32'h0, 0, 4'h0, 0, rd, lat, ncons, cdat);
      chk($sformatf("repro%0d_latency", i), 32'(lat), 32'(lats[i]));
    end
    chk("repro_rdata", rd, mdl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
